mem_arbiter: RTL

Shares one single-ported unified instruction/data memory between the pipeline's fetch stage and memory stage. It arbitrates requests and runs one memory transaction at a time under a variable-latency req/ack handshake. It returns read data with a one-cycle ready pulse and drives the fetch and memory stall signals that freeze the pipeline while an access is outstanding. A watchdog aborts transactions the memory never acknowledges.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/arb_watchdog.sv | 38 +++
 rtl/mem_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    DONE_IF,
    DONE_DM
  } arb_state_t;

  typedef enum logic {
    REQ_IF,
    REQ_DM
  } requester_t;

  localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/arb_watchdog.sv
// Saturating BUSY-cycle counter; expire_o flags the last BUSY cycle before an abort.
module arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != SAT)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q counts completed BUSY cycles, so LAST marks the TIMEOUT-th one.
  assign expire_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-ported memory between fetch and data
// stages, with registered req/ack handshake, ready pulses and watchdog abort.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_f,
  output logic              stall_m,
  output logic              err
);

  arb_state_t        state_q, state_d;
  requester_t        last_q, last_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ready_q, if_ready_d;
  logic              dm_ready_q, dm_ready_d;
  logic              err_q, err_d;
  logic              wd_clr, wd_en, wd_expire;

  assign wd_en = (state_q == BUSY_IF) || (state_q == BUSY_DM);

  arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (reset),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    err_d       = 1'b0;
    wd_clr      = 1'b0;

    case (state_q)
      IDLE: begin
        // DM wins unless IF also requests and DM was the one served last.
        if (dm_req && (!if_req || (last_q == REQ_IF))) begin
          state_d     = BUSY_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          wd_clr      = 1'b1;
        end else if (if_req) begin
          state_d    = BUSY_IF;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr;
          wd_clr     = 1'b1;
        end
      end

      BUSY_IF: begin
        if (mem_ack) begin
          state_d    = DONE_IF;
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata;
          if_ready_d = 1'b1;
          last_d     = REQ_IF;
        end else if (wd_expire) begin
          state_d    = DONE_IF;
          mem_req_d  = 1'b0;
          if_rdata_d = DATA_W'(ABORT_DATA);
          if_ready_d = 1'b1;
          err_d      = 1'b1;
          last_d     = REQ_IF;
        end
      end

      BUSY_DM: begin
        if (mem_ack) begin
          state_d    = DONE_DM;
          mem_req_d  = 1'b0;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
          dm_ready_d = 1'b1;
          last_d     = REQ_DM;
        end else if (wd_expire) begin
          state_d    = DONE_DM;
          mem_req_d  = 1'b0;
          dm_rdata_d = DATA_W'(ABORT_DATA);
          dm_ready_d = 1'b1;
          err_d      = 1'b1;
          last_d     = REQ_DM;
        end
      end

      DONE_IF, DONE_DM: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      last_q      <= REQ_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
      err_q       <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign err       = err_q;

  assign stall_f = if_req & ~if_ready_q;
  assign stall_m = dm_req & ~dm_ready_q;

endmodule
